fp_result_wb: RTL and testbench
===============================

Name: fp_result_wb

Overview:
Writeback stage directly downstream of the combinational single-precision add/sub datapath.
- Registers each accepted result and its four exception flags into a small FIFO.
- Presents the head entry to the consumer over a valid/ready handshake.
- Replaces the signalling NaN from the datapath with the canonical quiet NaN.
- Keeps sticky exception flags and a saturating exception counter, readable by status logic.

Parameters:
DEPTH, 2, FIFO entries; power of two, at least 2
TAG_W, 4, width of the opaque tag carried with each result
CNT_W, 16, width of the saturating exception counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  upstream result valid
in_ready  out  1  stage can accept; equals not-full
in_res  in  32  IEEE-754 single result from add/sub
in_ovf  in  1  exponent overflow flag
in_undf  in  1  exponent underflow flag
in_nan  in  1  NaN flag
in_zero  in  1  zero-result flag
in_tag  in  TAG_W  opaque tag
out_valid  out  1  head entry valid; equals not-empty
out_ready  in  1  consumer accepts
out_res  out  32  head result (NaN canonicalised)
out_flags  out  4  head flags {nan, ovf, undf, zero}
out_tag  out  TAG_W  head tag
count  out  $clog2(DEPTH)+1  occupancy
clr_sticky  in  1  synchronous clear of sticky flags and counter
sticky_flags  out  4  OR of accepted flags since last clear, order {nan, ovf, undf, zero}
exc_cnt  out  CNT_W  accepted entries with nan|ovf|undf, saturating

Behaviour:
Reset (asynchronous, may assert mid-transfer):
- Read/write pointers and count go to 0; out_valid=0; in_ready=1.
- sticky_flags=0, exc_cnt=0.
- out_res/out_flags/out_tag read the entry-0 storage; they are don't-care while out_valid=0, but storage resets to 0.
- Any in-flight entries are discarded.

Handshake:
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready depends only on count (count != DEPTH). There is no combinational path from out_ready to in_ready.
- out_valid = (count != 0), registered state only.
- Inputs are not inspected when in_valid=0.

Latency and ordering:
- 1 cycle minimum: data pushed at edge N is visible on out_* after edge N.
- No same-cycle bypass when empty.
- Strict FIFO order.

Boundary conditions:
- Full: in_ready=0, so a simultaneous pop frees a slot only from the next cycle; count goes DEPTH to DEPTH-1.
- Empty: out_valid=0; a push alone gives count 0 to 1.
- Simultaneous push and pop with 0<count<DEPTH: count unchanged; both pointers advance.
- Pointers wrap modulo DEPTH.
- out_* hold stable while out_valid=1 and out_ready=0.

Canonicalisation, applied at write time:
- If in_nan=1, stored result = 32'h7FC00000 regardless of in_res.
- Otherwise in_res is stored unchanged.
- Flags are stored as given.

Sticky flags and counter:
- Sticky update on push only, never on pop: sticky_next = (clr_sticky ? 0 : sticky_flags) | (push ? {in_nan, in_ovf, in_undf, in_zero} : 0).
- A flag arriving in the same cycle as a clear therefore survives.
- exc_cnt_next = (clr_sticky ? 0 : exc_cnt) + (push & (in_nan|in_ovf|in_undf)).
- The counter saturates at 2^CNT_W-1 and never wraps.
- When clear and an exception push coincide, the counter becomes 1.

Decomposition:
- Shared package fp_pkg:
  - typedef fp_flags_t, packed struct {nan, ovf, undf, zero};
  - constant FP_QNAN = 32'h7FC00000;
  - constant FP_FLAG_W = 4.
- One sub-module, fp_sync_fifo: parameterised width/depth storage, pointers and count, with async active-high reset.
- fp_result_wb instantiates fp_sync_fifo with width 32+4+TAG_W and adds the canonicalisation, sticky and counter logic.

Test Plan:
- Reset then single push: in_res=32'h40400000, flags 0, tag 3, out_ready=1 -> out_valid=1 the next cycle with out_res=32'h40400000, out_tag=3; out_valid=0 one cycle after that; count back to 0.
- NaN canonicalisation: push in_res=32'h7F800001, in_nan=1 -> out_res=32'h7FC00000, out_flags=4'b1000, sticky_flags=4'b1000, exc_cnt=1.
- Fill and backpressure: out_ready=0, push tags 1,2 -> in_ready=0 and count=2; third in_valid ignored; out_ready=1 for 2 cycles -> tags 1,2 pop in order, in_ready=1 again.
- Full with simultaneous push attempt and pop: count=2, in_valid=1, out_ready=1 -> only the pop occurs, count=1, then the push is accepted the following cycle.
- Clear racing a flag: sticky=4'b0100 (ovf), same cycle clr_sticky=1 and push with in_undf=1 -> sticky_flags=4'b0010, exc_cnt=1.
- Saturation and async reset: CNT_W=2, push 5 overflow results -> exc_cnt stays 3; assert rst mid-stream between edges -> count=0, out_valid=0, sticky_flags=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the fp add/sub writeback stage
package fp_pkg;

  localparam int FP_FLAG_W = 4;
  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef struct packed {
    logic nan;
    logic ovf;
    logic undf;
    logic zero;
  } fp_flags_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// rtl/fp_sync_fifo.sv - synchronous FIFO storage with pointers and occupancy count
module fp_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (i_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fp_result_wb.sv
// rtl/fp_result_wb.sv - buffers add/sub results, canonicalises NaN, tracks sticky flags
module fp_result_wb
  import fp_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_res,
  input  logic                     in_ovf,
  input  logic                     in_undf,
  input  logic                     in_nan,
  input  logic                     in_zero,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_res,
  output logic [FP_FLAG_W-1:0]     out_flags,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_sticky,
  output logic [FP_FLAG_W-1:0]     sticky_flags,
  output logic [CNT_W-1:0]         exc_cnt
);

  localparam int DW = 32 + FP_FLAG_W + TAG_W;

  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_empty;
  fp_flags_t       w_in_flags;
  fp_flags_t       w_out_flags;
  logic [31:0]     w_wr_res;
  logic [DW-1:0]   w_wdata;
  logic [DW-1:0]   w_rdata;
  logic            w_exc;
  logic [CNT_W-1:0] w_cnt_base;
  logic [FP_FLAG_W-1:0] w_sticky_base;

  fp_flags_t        r_sticky;
  logic [CNT_W-1:0] r_exc_cnt;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  assign w_in_flags = '{nan: in_nan, ovf: in_ovf, undf: in_undf, zero: in_zero};
  assign w_wr_res   = in_nan ? FP_QNAN : in_res;
  assign w_wdata    = {w_wr_res, w_in_flags, in_tag};

  fp_sync_fifo #(
    .WIDTH (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready    = ~w_full;
  assign out_valid   = ~w_empty;
  assign out_res     = w_rdata[DW-1 -: 32];
  assign w_out_flags = fp_flags_t'(w_rdata[TAG_W +: FP_FLAG_W]);
  assign out_flags   = w_out_flags;
  assign out_tag     = w_rdata[TAG_W-1:0];

  // Clear applies first so an event arriving alongside it is still recorded.
  assign w_exc         = w_push & (in_nan | in_ovf | in_undf);
  assign w_cnt_base    = clr_sticky ? '0 : r_exc_cnt;
  assign w_sticky_base = clr_sticky ? '0 : r_sticky;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky  <= '0;
      r_exc_cnt <= '0;
    end else begin
      r_sticky <= w_sticky_base | (w_push ? w_in_flags : '0);
      if (w_exc && (w_cnt_base != '1)) r_exc_cnt <= w_cnt_base + CNT_W'(1);
      else                             r_exc_cnt <= w_cnt_base;
    end
  end

  assign sticky_flags = r_sticky;
  assign exc_cnt      = r_exc_cnt;

endmodule

// File: tb/tb_fp_result_wb.sv
// tb/tb_fp_result_wb.sv - directed self-checking bench for fp_result_wb
module tb_fp_result_wb;

  localparam int DEPTH = 2;
  localparam int TAG_W = 4;
  localparam int CNT_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_res;
  logic              in_ovf, in_undf, in_nan, in_zero;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_res;
  logic [3:0]        out_flags;
  logic [TAG_W-1:0]  out_tag;
  logic [1:0]        count;
  logic              clr_sticky;
  logic [3:0]        sticky_flags;
  logic [CNT_W-1:0]  exc_cnt;

  int n_cmp = 0;
  int n_fail = 0;

  fp_result_wb #(.DEPTH(DEPTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_res       (in_res),
    .in_ovf       (in_ovf),
    .in_undf      (in_undf),
    .in_nan       (in_nan),
    .in_zero      (in_zero),
    .in_tag       (in_tag),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_res      (out_res),
    .out_flags    (out_flags),
    .out_tag      (out_tag),
    .count        (count),
    .clr_sticky   (clr_sticky),
    .sticky_flags (sticky_flags),
    .exc_cnt      (exc_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 0; in_res = '0; in_ovf = 0; in_undf = 0; in_nan = 0;
    in_zero = 0; in_tag = '0; out_ready = 0; clr_sticky = 0;
    tick(); tick();
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_sticky", 32'(sticky_flags), 0);
    chk("rst_exc_cnt", 32'(exc_cnt), 0);
    rst = 1'b0;
    tick();

    // single push, one cycle latency, then drains
    in_valid = 1; in_res = 32'h4040_0000; in_tag = 4'd3; out_ready = 1;
    chk("no_bypass", 32'(out_valid), 0);
    tick();
    in_valid = 0;
    chk("single_valid", 32'(out_valid), 1);
    chk("single_res", out_res, 32'h4040_0000);
    chk("single_tag", 32'(out_tag), 3);
    chk("single_count", 32'(count), 1);
    tick();
    chk("single_drain_valid", 32'(out_valid), 0);
    chk("single_drain_count", 32'(count), 0);

    // signalling NaN replaced by canonical quiet NaN
    in_valid = 1; in_res = 32'h7F80_0001; in_nan = 1; in_tag = 4'd7;
    tick();
    in_valid = 0; in_nan = 0;
    chk("nan_res", out_res, 32'h7FC0_0000);
    chk("nan_flags", 32'(out_flags), 32'h8);
    chk("nan_sticky", 32'(sticky_flags), 32'h8);
    chk("nan_exc_cnt", 32'(exc_cnt), 1);
    tick();
    clr_sticky = 1;
    tick();
    clr_sticky = 0;
    chk("clr_sticky", 32'(sticky_flags), 0);
    chk("clr_exc_cnt", 32'(exc_cnt), 0);

    // fill with backpressure, third push refused
    out_ready = 0; in_valid = 1; in_res = 32'h3F80_0000; in_tag = 4'd1;
    tick();
    in_tag = 4'd2;
    tick();
    chk("full_count", 32'(count), 2);
    chk("full_in_ready", 32'(in_ready), 0);
    in_tag = 4'd9;
    tick();
    chk("full_hold_count", 32'(count), 2);
    chk("full_hold_tag", 32'(out_tag), 1);
    in_valid = 0; out_ready = 1;
    tick();
    chk("pop1_tag", 32'(out_tag), 2);
    chk("pop1_count", 32'(count), 1);
    chk("pop1_in_ready", 32'(in_ready), 1);
    tick();
    chk("pop2_count", 32'(count), 0);

    // full: simultaneous push attempt and pop, only the pop happens
    out_ready = 0; in_valid = 1; in_tag = 4'd4;
    tick();
    in_tag = 4'd5;
    tick();
    in_tag = 4'd6; out_ready = 1;
    tick();
    chk("fullpop_count", 32'(count), 1);
    chk("fullpop_tag", 32'(out_tag), 5);
    out_ready = 0;
    tick();
    chk("late_push_count", 32'(count), 2);
    in_valid = 0; out_ready = 1;
    tick();
    chk("order_tag6", 32'(out_tag), 6);
    tick();
    chk("drain_count", 32'(count), 0);

    // clear coinciding with a new flag
    in_valid = 1; in_ovf = 1; in_tag = 4'd10;
    tick();
    chk("ovf_sticky", 32'(sticky_flags), 32'h4);
    chk("ovf_exc_cnt", 32'(exc_cnt), 1);
    in_ovf = 0; in_undf = 1; clr_sticky = 1; in_tag = 4'd11;
    tick();
    chk("race_sticky", 32'(sticky_flags), 32'h2);
    chk("race_exc_cnt", 32'(exc_cnt), 1);
    chk("race_flags", 32'(out_flags), 32'h2);
    chk("race_count", 32'(count), 1);
    clr_sticky = 0; in_valid = 0; in_undf = 0;
    tick();
    clr_sticky = 1;
    tick();
    clr_sticky = 0;

    // counter saturation at 3 with CNT_W=2
    in_valid = 1; in_ovf = 1;
    tick(); tick(); tick();
    chk("sat_cnt3", 32'(exc_cnt), 3);
    tick(); tick();
    chk("sat_cnt5", 32'(exc_cnt), 3);
    chk("sat_count", 32'(count), 1);

    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_sticky", 32'(sticky_flags), 0);
    chk("arst_exc_cnt", 32'(exc_cnt), 0);
    chk("arst_in_ready", 32'(in_ready), 1);
    in_valid = 0; in_ovf = 0;
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
